// File: rtl/jk_counter_pkg.sv
// Shared types and helpers for the JK-stage modulo counter.
package jk_counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef struct packed {
        logic j;
        logic k;
    } jk_ctrl_t;

    // Toggle-form drive: J=K=1 only where the bit must change, otherwise hold.
    function automatic jk_ctrl_t jk_for(input logic cur, input logic nxt);
        jk_ctrl_t c;
        c.j = cur ^ nxt;
        c.k = cur ^ nxt;
        return c;
    endfunction

endpackage

// File: rtl/jk_stage.sv
// One JK flip-flop bit with synchronous active-low reset.
module jk_stage (
    input  logic clk,
    input  logic reset_n,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = q_q;
        unique case ({j, k})
            2'b00:   q_d = q_q;
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            default: q_d = ~q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) q_q <= 1'b0;
        else          q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter built from JK stages, with a registered wrap
// pulse and a divide-by-2*MODULUS square wave.
module jk_mod_counter
    import jk_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             div_out
);

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("jk_mod_counter: WIDTH must be 1..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("jk_mod_counter: MODULUS must be 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_next;
    logic             wrap_d;
    logic             wrap_q;
    logic             force_load;
    jk_ctrl_t [WIDTH-1:0] stage_jk;
    logic             div_q;

    always_comb begin
        cnt_next   = cnt_q;
        wrap_d     = 1'b0;
        force_load = 1'b0;
        if (load) begin
            force_load = 1'b1;
            cnt_next   = (load_val > CNT_MAX) ? CNT_MAX : load_val;
        end else if (en) begin
            if (up_dn == DIR_UP) begin
                if (cnt_q >= CNT_MAX) begin
                    cnt_next = '0;
                    wrap_d   = 1'b1;
                end else begin
                    cnt_next = cnt_q + WIDTH'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_next = CNT_MAX;
                    wrap_d   = 1'b1;
                end else begin
                    cnt_next = cnt_q - WIDTH'(1);
                end
            end
        end
    end

    // Wrap and load jump to an arbitrary value, so drive set/reset form there.
    always_comb begin
        stage_jk = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (force_load || wrap_d) begin
                stage_jk[i].j = cnt_next[i];
                stage_jk[i].k = ~cnt_next[i];
            end else begin
                stage_jk[i] = jk_for(cnt_q[i], cnt_next[i]);
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        jk_stage u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .j       (stage_jk[g].j),
            .k       (stage_jk[g].k),
            .q       (cnt_q[g])
        );
    end

    jk_stage u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .j       (wrap_d),
        .k       (wrap_d),
        .q       (div_q)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) wrap_q <= 1'b0;
        else          wrap_q <= wrap_d;
    end

    assign count   = cnt_q;
    assign wrap    = wrap_q;
    assign div_out = div_q;

endmodule
